transfer_gate_unit: RTL and testbench

- 16-bit bus transfer-gate unit for the processor datapath.
- Four AND-type transfer gates steer data from the internal S bus and the memory M bus:
  - SMA: S bus -> memory address
  - SMD: S bus -> memory data
  - MMD: M bus -> memory data
  - MIS: M bus -> instruction
- Each gate output is combinational (same-cycle) and is zero when its gate is off.
- The unit also captures gated values into MAR, MDR and IR registers on the clock edge.

---
 rtl/transfer_gate_unit_if.sv | 34 +++
 rtl/transfer_gate_unit.sv | 91 +++++++++
 tb/tb_transfer_gate_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/transfer_gate_unit_if.sv
// Bus bundle for the transfer-gate unit: the S/M source buses, the four gate
// enables, the gated outputs and the captured MAR/MDR/IR registers.
interface transfer_gate_unit_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] S_bus;
    logic [WIDTH-1:0] M_bus;
    logic             SMA;
    logic             SMD;
    logic             MMD;
    logic             MIS;
    logic [WIDTH-1:0] SMA_out;
    logic [WIDTH-1:0] SMD_out;
    logic [WIDTH-1:0] MMD_out;
    logic [WIDTH-1:0] MIS_out;
    logic [WIDTH-1:0] mar_q;
    logic [WIDTH-1:0] mdr_q;
    logic [WIDTH-1:0] ir_q;
    logic             mdr_conflict;

    // Datapath control side: drives buses and enables, observes results.
    modport master (
        output S_bus, M_bus, SMA, SMD, MMD, MIS,
        input  SMA_out, SMD_out, MMD_out, MIS_out,
        input  mar_q, mdr_q, ir_q, mdr_conflict
    );

    // Gate unit side.
    modport slave (
        input  S_bus, M_bus, SMA, SMD, MMD, MIS,
        output SMA_out, SMD_out, MMD_out, MIS_out,
        output mar_q, mdr_q, ir_q, mdr_conflict
    );
endinterface

// File: rtl/transfer_gate_unit.sv
// Transfer-gate unit: four independent AND-type gates steer the S and M buses
// onto address/data/instruction paths, and the gated values are captured into
// MAR, MDR and IR on the rising clock edge.

// One AND-type gate: a disabled gate drives exactly zero.
module tgu_gate #(
    parameter int WIDTH = 16
) (
    input  logic             en_i,
    input  logic [WIDTH-1:0] bus_i,
    output logic [WIDTH-1:0] out_o
);
    assign out_o = bus_i & {WIDTH{en_i}};
endmodule

module transfer_gate_unit #(
    parameter int WIDTH = 16
) (
    input logic                clk,
    input logic                rst_n,
    transfer_gate_unit_if.slave bus
);
    localparam int NUM_GATES = 4;
    localparam int G_SMA = 0;
    localparam int G_SMD = 1;
    localparam int G_MMD = 2;
    localparam int G_MIS = 3;

    logic [NUM_GATES-1:0]            gate_en;
    logic [NUM_GATES-1:0][WIDTH-1:0] gate_bus;
    logic [NUM_GATES-1:0][WIDTH-1:0] gate_out;

    logic [WIDTH-1:0] mar_q, mar_d;
    logic [WIDTH-1:0] mdr_q, mdr_d;
    logic [WIDTH-1:0] ir_q,  ir_d;
    logic             cf_q,  cf_d;

    // Gate index order matches the G_* constants (MSB first in the concat).
    assign gate_en  = {bus.MIS, bus.MMD, bus.SMD, bus.SMA};
    assign gate_bus = {bus.M_bus, bus.M_bus, bus.S_bus, bus.S_bus};

    generate
        for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
            tgu_gate #(.WIDTH(WIDTH)) u_gate (
                .en_i  (gate_en[g]),
                .bus_i (gate_bus[g]),
                .out_o (gate_out[g])
            );
        end
    endgenerate

    assign bus.SMA_out = gate_out[G_SMA];
    assign bus.SMD_out = gate_out[G_SMD];
    assign bus.MMD_out = gate_out[G_MMD];
    assign bus.MIS_out = gate_out[G_MIS];

    // Next-state: load from the same-cycle gate output, otherwise hold.
    // SMD and MMD together model a wired-OR merge onto the MDR input.
    always_comb begin
        mar_d = mar_q;
        mdr_d = mdr_q;
        ir_d  = ir_q;
        cf_d  = gate_en[G_SMD] & gate_en[G_MMD];
        if (gate_en[G_SMA])
            mar_d = gate_out[G_SMA];
        if (gate_en[G_SMD] | gate_en[G_MMD])
            mdr_d = gate_out[G_SMD] | gate_out[G_MMD];
        if (gate_en[G_MIS])
            ir_d = gate_out[G_MIS];
    end

    // Register bank with asynchronous clear; the conflict flag is not sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mar_q <= '0;
            mdr_q <= '0;
            ir_q  <= '0;
            cf_q  <= 1'b0;
        end else begin
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            ir_q  <= ir_d;
            cf_q  <= cf_d;
        end
    end

    assign bus.mar_q        = mar_q;
    assign bus.mdr_q        = mdr_q;
    assign bus.ir_q         = ir_q;
    assign bus.mdr_conflict = cf_q;
endmodule

// File: tb/tb_transfer_gate_unit.sv
// Directed bench for transfer_gate_unit. Expected values are pushed onto a
// scoreboard queue as stimulus is driven and popped when outputs are sampled.
module tb_transfer_gate_unit;
    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb[$];
    int   tests;
    int   fails;

    // Reference register state, updated from the stimulus the bench drives.
    logic [15:0] m_mar, m_mdr, m_ir;
    logic        m_cf;

    transfer_gate_unit_if #(.WIDTH(16)) bus ();

    transfer_gate_unit #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [15:0] obs);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL sb_empty observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                fails++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // Drive buses/enables, then compare the four combinational gate outputs.
    task automatic drive(input logic [15:0] s, input logic [15:0] m,
                         input logic a, input logic b, input logic c, input logic d);
        bus.S_bus = s;
        bus.M_bus = m;
        bus.SMA   = a;
        bus.SMD   = b;
        bus.MMD   = c;
        bus.MIS   = d;
        push("SMA_out", a ? s : 16'h0000);
        push("SMD_out", b ? s : 16'h0000);
        push("MMD_out", c ? m : 16'h0000);
        push("MIS_out", d ? m : 16'h0000);
        #1;
        check(bus.SMA_out);
        check(bus.SMD_out);
        check(bus.MMD_out);
        check(bus.MIS_out);
    endtask

    task automatic regs_now(input string tag);
        push({tag, "_mar"}, m_mar);
        push({tag, "_mdr"}, m_mdr);
        push({tag, "_ir"},  m_ir);
        push({tag, "_cf"},  {15'b0, m_cf});
        check(bus.mar_q);
        check(bus.mdr_q);
        check(bus.ir_q);
        check({15'b0, bus.mdr_conflict});
    endtask

    // Advance one clock edge and compare registers against the model.
    task automatic tick(input string tag);
        if (bus.SMA) m_mar = bus.S_bus;
        if (bus.SMD | bus.MMD)
            m_mdr = (bus.SMD ? bus.S_bus : 16'h0) | (bus.MMD ? bus.M_bus : 16'h0);
        if (bus.MIS) m_ir = bus.M_bus;
        m_cf = bus.SMD & bus.MMD;
        @(posedge clk);
        #1;
        regs_now(tag);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        m_mar = '0; m_mdr = '0; m_ir = '0; m_cf = 1'b0;
        rst_n = 1'b0;

        // Reset with every gate off: outputs zero, registers cleared.
        drive(16'hFFFF, 16'hFFFF, 0, 0, 0, 0);
        regs_now("rst");
        // Gates stay live while reset is held.
        drive(16'hFFFF, 16'hFFFF, 1, 0, 0, 1);
        drive(16'hFFFF, 16'hFFFF, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick("idle0");
        tick("idle1");
        tick("idle2");

        // Single-gate passthrough.
        drive(16'hAAAA, 16'h0000, 1, 0, 0, 0);
        tick("sma");
        drive(16'h5555, 16'h0000, 0, 1, 0, 0);
        tick("smd");
        drive(16'h0000, 16'h1234, 0, 0, 1, 0);
        tick("mmd");
        drive(16'h0000, 16'hABCD, 0, 0, 0, 1);
        tick("mis");
        drive(16'h0000, 16'h0000, 0, 0, 0, 0);
        tick("off");

        // Same-bus gates together.
        drive(16'hBEEF, 16'h0000, 1, 1, 0, 0);
        tick("same");

        // Both MDR sources: wired-OR merge and conflict flag.
        drive(16'hF0F0, 16'h0F0F, 0, 1, 1, 0);
        tick("mix");
        push("mix_mdr_const", 16'hFFFF);
        check(bus.mdr_q);
        push("mix_cf_const", 16'h0001);
        check({15'b0, bus.mdr_conflict});
        drive(16'hF0F0, 16'h0F0F, 0, 1, 0, 0);
        tick("cf_clear");

        // Load MAR, then hold it while the buses toggle.
        drive(16'h1357, 16'h2222, 1, 0, 0, 1);
        tick("load");
        drive(16'hFFFF, 16'h0000, 0, 0, 0, 0);
        tick("hold0");
        drive(16'h0000, 16'hFFFF, 0, 0, 0, 0);
        tick("hold1");
        push("hold_mar_const", 16'h1357);
        check(bus.mar_q);

        // Asynchronous reset mid-cycle, gates still tracking enables.
        #1 rst_n = 1'b0;
        m_mar = '0; m_mdr = '0; m_ir = '0; m_cf = 1'b0;
        #1;
        regs_now("async");
        drive(16'h2468, 16'h9999, 1, 0, 1, 0);
        // First edge after release loads normally with enables already high.
        rst_n = 1'b1;
        tick("post_rst");
        drive(16'h0000, 16'h0000, 0, 0, 0, 0);
        tick("final");

        if (sb.size() != 0) begin
            tests++;
            fails++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety bound on simulated time.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
